// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared encodings for execute-stage forwarding and the multi-cycle scoreboard.
// Pure declarations: no logic, no latency, no flow control.
package hazard_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] FWD_REGFILE = 3'b000;
  localparam logic [SEL_W-1:0] FWD_WB      = 3'b001;
  localparam logic [SEL_W-1:0] FWD_MEM     = 3'b010;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // A producer writing both files satisfies either reader class.
  function automatic logic class_match(input logic rs_vec, input logic wre, input logic wre_vec);
    return rs_vec ? wre_vec : wre;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Pipeline-side bundle of decode/execute/memory/writeback fields and hazard controls.
// master = pipeline registers driving the hazard unit; slave = the hazard unit itself.
interface fwd_hazard_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_AW-1:0] rs_decode;
  logic [NUM_SRC-1:0]        rs_vec_decode;
  logic [NUM_SRC-1:0]        rs_used_decode;
  logic [REG_AW-1:0]         rd_decode;
  logic                      mc_issue_decode;
  logic [NUM_SRC*REG_AW-1:0] rs_execute;
  logic [NUM_SRC-1:0]        rs_vec_execute;
  logic [REG_AW-1:0]         rd_execute;
  logic                      wre_execute;
  logic                      wre_vector_execute;
  logic                      mem_read_execute;
  logic [REG_AW-1:0]         rd_memory;
  logic                      wre_memory;
  logic                      wre_vector_memory;
  logic [REG_AW-1:0]         rd_writeback;
  logic                      wre_writeback;
  logic                      wre_vector_writeback;
  logic [NUM_SRC*3-1:0]      select_forward;
  logic                      stall_fetch;
  logic                      stall_decode;
  logic                      flush_execute;
  logic                      mc_busy;
  logic [REG_AW-1:0]         mc_rd;
  logic                      mc_done;

  modport master (
    output rs_decode, rs_vec_decode, rs_used_decode, rd_decode, mc_issue_decode,
           rs_execute, rs_vec_execute, rd_execute, wre_execute, wre_vector_execute,
           mem_read_execute, rd_memory, wre_memory, wre_vector_memory,
           rd_writeback, wre_writeback, wre_vector_writeback,
    input  select_forward, stall_fetch, stall_decode, flush_execute, mc_busy, mc_rd, mc_done
  );

  modport slave (
    input  rs_decode, rs_vec_decode, rs_used_decode, rd_decode, mc_issue_decode,
           rs_execute, rs_vec_execute, rd_execute, wre_execute, wre_vector_execute,
           mem_read_execute, rd_memory, wre_memory, wre_vector_memory,
           rd_writeback, wre_writeback, wre_vector_writeback,
    output select_forward, stall_fetch, stall_decode, flush_execute, mc_busy, mc_rd, mc_done
  );
endinterface

// File: rtl/fwd_hazard_scoreboard_fwd_select.sv
// Single-operand class-aware forwarding priority selector (memory over writeback).
// Purely combinational, zero latency, no flow control.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter bit ZERO_HARDWIRED = 1'b0
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_rs_vec,
  input  logic [REG_AW-1:0] i_rd_mem,
  input  logic              i_wre_mem,
  input  logic              i_wre_vec_mem,
  input  logic [REG_AW-1:0] i_rd_wb,
  input  logic              i_wre_wb,
  input  logic              i_wre_vec_wb,
  output logic [SEL_W-1:0]  o_sel
);

  logic w_zero;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_zero    = ZERO_HARDWIRED && (i_rs == '0);
  assign w_hit_mem = (i_rs == i_rd_mem) && class_match(i_rs_vec, i_wre_mem, i_wre_vec_mem);
  assign w_hit_wb  = (i_rs == i_rd_wb)  && class_match(i_rs_vec, i_wre_wb,  i_wre_vec_wb);

  always_comb begin
    o_sel = FWD_REGFILE;
    if (!w_zero) begin
      if (w_hit_mem)     o_sel = FWD_MEM;
      else if (w_hit_wb) o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Execute-stage forwarding selects, load-use/multi-cycle stall detection, single-entry mc scoreboard.
// Selects and stall/flush are combinational (0 cycles); mc_busy/mc_rd/mc_done are registered.
module fwd_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 2,
  parameter int MC_LAT         = 4,
  parameter bit ZERO_HARDWIRED = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam int CNT_W = $clog2(MC_LAT + 1);

  mc_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [REG_AW-1:0]    r_mc_rd;
  logic                 r_mc_done;
  logic [NUM_SRC*3-1:0] w_sel;
  logic                 w_lu_hit;
  logic                 w_mc_hit;
  logic                 w_busy;
  logic                 w_stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_select #(
      .REG_AW        (REG_AW),
      .ZERO_HARDWIRED(ZERO_HARDWIRED)
    ) u_fwd_select (
      .i_rs         (bus.rs_execute[g*REG_AW +: REG_AW]),
      .i_rs_vec     (bus.rs_vec_execute[g]),
      .i_rd_mem     (bus.rd_memory),
      .i_wre_mem    (bus.wre_memory),
      .i_wre_vec_mem(bus.wre_vector_memory),
      .i_rd_wb      (bus.rd_writeback),
      .i_wre_wb     (bus.wre_writeback),
      .i_wre_vec_wb (bus.wre_vector_writeback),
      .o_sel        (w_sel[g*3 +: 3])
    );
  end

  always_comb begin : p_hit
    logic [REG_AW-1:0] v_rs;
    logic              v_ok;
    w_lu_hit = 1'b0;
    w_mc_hit = 1'b0;
    v_rs     = '0;
    v_ok     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      v_rs = bus.rs_decode[i*REG_AW +: REG_AW];
      v_ok = bus.rs_used_decode[i] && !(ZERO_HARDWIRED && (v_rs == '0));
      if (v_ok && (v_rs == bus.rd_execute) &&
          class_match(bus.rs_vec_decode[i], bus.wre_execute, bus.wre_vector_execute))
        w_lu_hit = 1'b1;
      if (v_ok && bus.rs_vec_decode[i] && (v_rs == r_mc_rd))
        w_mc_hit = 1'b1;
    end
  end

  assign w_busy  = (r_state == MC_BUSY);
  assign w_stall = (bus.mem_read_execute && w_lu_hit) ||
                   (w_busy && (w_mc_hit || bus.mc_issue_decode));

  // mc_done is registered so that it is high during the last BUSY cycle (cnt==0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MC_IDLE;
      r_cnt     <= '0;
      r_mc_rd   <= '0;
      r_mc_done <= 1'b0;
    end else begin
      r_mc_done <= 1'b0;
      case (r_state)
        MC_IDLE: begin
          if (bus.mc_issue_decode && !w_stall) begin
            r_state   <= MC_BUSY;
            r_cnt     <= CNT_W'(MC_LAT - 1);
            r_mc_rd   <= bus.rd_decode;
            r_mc_done <= (MC_LAT == 1);
          end
        end
        MC_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt     <= r_cnt - CNT_W'(1);
            r_mc_done <= (r_cnt == CNT_W'(1));
          end else begin
            r_state <= MC_IDLE;
          end
        end
        default: r_state <= MC_IDLE;
      endcase
    end
  end

  assign bus.select_forward = w_sel;
  assign bus.stall_fetch    = w_stall;
  assign bus.stall_decode   = w_stall;
  assign bus.flush_execute  = w_stall;
  assign bus.mc_busy        = w_busy;
  assign bus.mc_rd          = r_mc_rd;
  assign bus.mc_done        = r_mc_done;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// dut0 has ZERO_HARDWIRED=0, dut1 has ZERO_HARDWIRED=1.
module tb_fwd_hazard_scoreboard;

  typedef struct packed {
    logic [5:0] sel;
    logic [2:0] stl;
    logic       busy;
    logic       done;
    logic [4:0] rd;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  obs_t  q_exp[$];
  bit    q_dut[$];
  string q_nm[$];

  fwd_hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(2)) if0 ();
  fwd_hazard_scoreboard_if #(.REG_AW(5), .NUM_SRC(2)) if1 ();

  fwd_hazard_scoreboard #(
    .REG_AW(5), .NUM_SRC(2), .MC_LAT(4), .ZERO_HARDWIRED(1'b0)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0)
  );

  fwd_hazard_scoreboard #(
    .REG_AW(5), .NUM_SRC(2), .MC_LAT(4), .ZERO_HARDWIRED(1'b1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  obs_t obs0;
  obs_t obs1;
  assign obs0 = {if0.select_forward, if0.stall_fetch, if0.stall_decode, if0.flush_execute,
                 if0.mc_busy, if0.mc_done, if0.mc_rd};
  assign obs1 = {if1.select_forward, if1.stall_fetch, if1.stall_decode, if1.flush_execute,
                 if1.mc_busy, if1.mc_done, if1.mc_rd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    obs_t  e;
    obs_t  a;
    bit    d;
    string nm;
    forever begin
      @(negedge clk);
      while (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        d  = q_dut.pop_front();
        nm = q_nm.pop_front();
        a  = d ? obs1 : obs0;
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s dut%0d: got sel=%b stall=%b busy=%b done=%b rd=%0d, want sel=%b stall=%b busy=%b done=%b rd=%0d",
                   nm, d, a.sel, a.stl, a.busy, a.done, a.rd, e.sel, e.stl, e.busy, e.done, e.rd);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit d, input string nm, input logic [5:0] sel, input logic stl,
                     input logic busy, input logic done, input logic [4:0] rd);
    obs_t e;
    e = '{sel: sel, stl: {3{stl}}, busy: busy, done: done, rd: rd};
    q_exp.push_back(e);
    q_dut.push_back(d);
    q_nm.push_back(nm);
  endtask

  task automatic idle();
    if0.rs_decode = '0; if0.rs_vec_decode = '0; if0.rs_used_decode = '0; if0.rd_decode = '0;
    if0.mc_issue_decode = 1'b0; if0.rs_execute = '0; if0.rs_vec_execute = '0; if0.rd_execute = '0;
    if0.wre_execute = 1'b0; if0.wre_vector_execute = 1'b0; if0.mem_read_execute = 1'b0;
    if0.rd_memory = '0; if0.wre_memory = 1'b0; if0.wre_vector_memory = 1'b0;
    if0.rd_writeback = '0; if0.wre_writeback = 1'b0; if0.wre_vector_writeback = 1'b0;
    if1.rs_decode = '0; if1.rs_vec_decode = '0; if1.rs_used_decode = '0; if1.rd_decode = '0;
    if1.mc_issue_decode = 1'b0; if1.rs_execute = '0; if1.rs_vec_execute = '0; if1.rd_execute = '0;
    if1.wre_execute = 1'b0; if1.wre_vector_execute = 1'b0; if1.mem_read_execute = 1'b0;
    if1.rd_memory = '0; if1.wre_memory = 1'b0; if1.wre_vector_memory = 1'b0;
    if1.rd_writeback = '0; if1.wre_writeback = 1'b0; if1.wre_vector_writeback = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    #1;
    chk(0, "reset", 6'b000000, 0, 0, 0, 5'd0);
    nxt();
    rst_n = 1'b1;

    // Forwarding priority and class separation
    nxt(); idle();
    if0.rs_execute = {5'd0, 5'd5}; if0.wre_memory = 1; if0.rd_memory = 5;
    if0.wre_writeback = 1; if0.rd_writeback = 5;
    chk(0, "fwd_mem_pri", 6'b000_010, 0, 0, 0, 5'd0);
    nxt(); if0.wre_memory = 0;
    chk(0, "fwd_wb", 6'b000_001, 0, 0, 0, 5'd0);
    nxt(); if0.rs_execute = {5'd5, 5'd6};
    chk(0, "fwd_src1_wb", 6'b001_000, 0, 0, 0, 5'd0);
    nxt(); idle();
    if0.rs_execute = {5'd0, 5'd3}; if0.rs_vec_execute = 2'b01; if0.wre_memory = 1; if0.rd_memory = 3;
    chk(0, "vec_cls_miss", 6'b000_000, 0, 0, 0, 5'd0);
    nxt(); if0.wre_vector_memory = 1;
    chk(0, "vec_mem", 6'b000_010, 0, 0, 0, 5'd0);

    // Load-use
    nxt(); idle();
    if0.mem_read_execute = 1; if0.wre_execute = 1; if0.rd_execute = 7;
    if0.rs_decode = {5'd7, 5'd0}; if0.rs_used_decode = 2'b10;
    chk(0, "lu_stall", 6'b000_000, 1, 0, 0, 5'd0);
    nxt(); if0.rs_used_decode = 2'b00;
    chk(0, "lu_unused", 6'b000_000, 0, 0, 0, 5'd0);
    nxt(); if0.rs_used_decode = 2'b10; if0.rs_vec_decode = 2'b10;
    chk(0, "lu_cls_miss", 6'b000_000, 0, 0, 0, 5'd0);

    // Multi-cycle op, rd=9
    nxt(); idle(); if0.mc_issue_decode = 1; if0.rd_decode = 9;
    chk(0, "mc_issue", 6'b0, 0, 0, 0, 5'd0);
    nxt(); if0.mc_issue_decode = 0;
    if0.rs_decode = {5'd0, 5'd9}; if0.rs_vec_decode = 2'b01; if0.rs_used_decode = 2'b01;
    chk(0, "mc_t1_v9", 6'b0, 1, 1, 0, 5'd9);
    nxt(); if0.rs_decode = {5'd0, 5'd8};
    chk(0, "mc_t2_v8", 6'b0, 0, 1, 0, 5'd9);
    nxt(); if0.rs_decode = {5'd0, 5'd9};
    chk(0, "mc_t3_v9", 6'b0, 1, 1, 0, 5'd9);
    nxt();
    chk(0, "mc_t4_done", 6'b0, 1, 1, 1, 5'd9);
    nxt();
    chk(0, "mc_t5_free", 6'b0, 0, 0, 0, 5'd9);

    // Back-to-back issue is held until the first op drains
    nxt(); idle(); if0.mc_issue_decode = 1; if0.rd_decode = 12;
    chk(0, "mc2_issue", 6'b0, 0, 0, 0, 5'd9);
    for (int k = 1; k <= 4; k++) begin
      nxt(); if0.rd_decode = 13;
      chk(0, "mc2_held", 6'b0, 1, 1, (k == 4), 5'd12);
    end
    nxt();
    chk(0, "mc2_accept", 6'b0, 0, 0, 0, 5'd12);
    nxt(); if0.mc_issue_decode = 0;
    chk(0, "mc2_busy6", 6'b0, 0, 1, 0, 5'd13);
    nxt(); chk(0, "mc2_busy7", 6'b0, 0, 1, 0, 5'd13);
    nxt(); chk(0, "mc2_busy8", 6'b0, 0, 1, 0, 5'd13);
    nxt(); chk(0, "mc2_done9", 6'b0, 0, 1, 1, 5'd13);
    nxt(); chk(0, "mc2_idle", 6'b0, 0, 0, 0, 5'd13);

    // Reset in the middle of an op
    nxt(); idle(); if0.mc_issue_decode = 1; if0.rd_decode = 20;
    chk(0, "mc3_issue", 6'b0, 0, 0, 0, 5'd13);
    nxt(); if0.mc_issue_decode = 0;
    chk(0, "mc3_busy", 6'b0, 0, 1, 0, 5'd20);
    nxt(); rst_n = 1'b0;
    if0.rs_execute = {5'd0, 5'd4}; if0.wre_memory = 1; if0.rd_memory = 4;
    chk(0, "rst_async", 6'b000_010, 0, 0, 0, 5'd0);
    nxt(); rst_n = 1'b1; idle();
    chk(0, "rst_release", 6'b0, 0, 0, 0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk(0, "rst_no_pulse", 6'b0, 0, 0, 0, 5'd0);
    end

    // Register 0 hardwired on dut1, ordinary on dut0
    nxt(); idle();
    if0.wre_memory = 1; if0.rd_memory = 0; if0.mem_read_execute = 1; if0.wre_execute = 1;
    if0.rd_execute = 0; if0.rs_used_decode = 2'b01;
    if1.wre_memory = 1; if1.rd_memory = 0; if1.mem_read_execute = 1; if1.wre_execute = 1;
    if1.rd_execute = 0; if1.rs_used_decode = 2'b01;
    chk(1, "zero_hw", 6'b000_000, 0, 0, 0, 5'd0);
    chk(0, "zero_soft", 6'b010_010, 1, 0, 0, 5'd0);
    nxt();
    if1.rs_execute = {5'd0, 5'd6}; if1.rd_memory = 6;
    chk(1, "zero_hw_nz", 6'b000_010, 0, 0, 0, 5'd0);

    nxt(); idle();
    for (int k = 0; k < 5 && q_exp.size() != 0; k++) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
